// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and helpers for the rsp_s2 prep-stage chunk-serial arithmetic blocks.
package rsp_s2_prep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // The chunk index is never narrower than one bit, even for a single-chunk build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsp_s2_prep_sub_u.sv
// Combinational single-chunk subtractor: out_num = num1 - num2 - i_b, o_b = borrow-out.
module rsp_s2_prep_sub_u #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] num1,
    input  logic [DATA_WIDTH-1:0] num2,
    input  logic                  i_b,
    output logic [DATA_WIDTH-1:0] out_num,
    output logic                  o_b
);

    logic [DATA_WIDTH:0] w_diff;

    // One extra bit on top: it goes high exactly when the chunk difference is negative.
    always_comb begin
        w_diff  = {1'b0, num1} - {1'b0, num2} - {{DATA_WIDTH{1'b0}}, i_b};
        out_num = w_diff[DATA_WIDTH-1:0];
        o_b     = w_diff[DATA_WIDTH];
    end

endmodule

// File: rtl/rsp_s2_prep_sub_seq.sv
// Chunk-serial wide subtractor with borrow, LSB chunk first, valid/ready on both sides.
// Optional macro RSP_S2_PREP_SUB_SAT_EN: saturate the result to 0 on final underflow.
module rsp_s2_prep_sub_seq
    import rsp_s2_prep_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CHUNKS = 4,
    localparam int unsigned W         = DATA_WIDTH * NUM_CHUNKS
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    input  logic         i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] out_num,
    output logic         o_b
);

    localparam int unsigned      IDX_W    = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [W-1:0]            r_a;
    logic [W-1:0]            r_bsub;
    logic [W-1:0]            r_res;
    logic                    r_borrow;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_a_chunk;
    logic [DATA_WIDTH-1:0]   w_b_chunk;
    logic [DATA_WIDTH-1:0]   w_diff;
    logic                    w_bout;

    always_comb begin
        w_a_chunk = r_a[r_idx*DATA_WIDTH +: DATA_WIDTH];
        w_b_chunk = r_bsub[r_idx*DATA_WIDTH +: DATA_WIDTH];
        w_last    = (r_idx == LAST_IDX);
    end

    rsp_s2_prep_sub_u #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sub (
        .num1    (w_a_chunk),
        .num2    (w_b_chunk),
        .i_b     (r_borrow),
        .out_num (w_diff),
        .o_b     (w_bout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            StIdle: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_bsub   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_a      <= num1;
                        r_bsub   <= num2;
                        r_borrow <= i_b;
                        r_res    <= '0;
                        r_idx    <= '0;
                    end
                end
                StRun: begin
                    r_res[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_diff;
                    r_borrow                              <= w_bout;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
`ifdef RSP_S2_PREP_SUB_SAT_EN
                    // Later assignment wins: floor the whole result on final underflow.
                    if (w_last && w_bout) begin
                        r_res <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_num = r_res;
    assign o_b     = r_borrow;

endmodule

// File: tb/tb_rsp_s2_prep_sub_seq.sv
// Self-checking bench for rsp_s2_prep_sub_seq (16-bit chunks, 2 chunks) with a transaction model.
module tb_rsp_s2_prep_sub_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned W  = DW * NC;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] out_num;
    logic         o_b;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    rsp_s2_prep_sub_seq #(
        .DATA_WIDTH (DW),
        .NUM_CHUNKS (NC)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .num1    (num1),
        .num2    (num2),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .out_num (out_num),
        .o_b     (o_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy flag, cycles since accept, expected result.
    bit           m_busy = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_exp  = '0;
    logic         m_expb = 1'b0;
    logic [W-1:0] m_last = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_last = '0;
        end else if (!m_busy) begin
            if (i_valid) begin
                logic [63:0] d;
                d      = {32'd0, num1} - {32'd0, num2} - {63'd0, i_b};
                m_expb = ({32'd0, num1} < ({32'd0, num2} + {63'd0, i_b}));
                m_exp  = d[W-1:0];
`ifdef RSP_S2_PREP_SUB_SAT_EN
                if (m_expb) m_exp = '0;
`endif
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (m_cnt >= NC) begin
            if (i_ready) begin
                m_busy = 1'b0;
                m_last = m_exp;
            end
        end else begin
            m_cnt++;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en && i_rst_n) begin
            check("o_ready", {63'd0, o_ready}, {63'd0, !m_busy});
            check("o_valid", {63'd0, o_valid}, {63'd0, (m_busy && m_cnt >= NC)});
            if (m_busy && m_cnt >= NC) begin
                check("out_num", {32'd0, out_num}, {32'd0, m_exp});
                check("o_b", {63'd0, o_b}, {63'd0, m_expb});
            end else if (!m_busy) begin
                check("out_num_hold", {32'd0, out_num}, {32'd0, m_last});
            end
        end
    end

    // Issue one operation and return the result seen when o_valid rises.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb, input logic b,
                          input logic rdy, output logic [W-1:0] got, output logic gotb,
                          output int lat);
        int g = 0;
        @(negedge i_clk);
        while (!o_ready && g < 50) begin
            @(negedge i_clk);
            g++;
        end
        if (g >= 50) check("wait_ready_timeout", 64'd1, 64'd0);
        num1    = a;
        num2    = bb;
        i_b     = b;
        i_valid = 1'b1;
        i_ready = rdy;
        @(negedge i_clk);
        i_valid = 1'b0;
        num1    = $urandom;
        num2    = $urandom;
        i_b     = 1'($urandom);
        lat     = 0;
        while (!o_valid && lat < 20) begin
            lat++;
            @(negedge i_clk);
        end
        got  = out_num;
        gotb = o_b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] hold_num;
        logic         gotb;
        logic         hold_b;
        int           lat;
        int           prev;
        int           accepts;
        int           guard;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        num1    = '0;
        num2    = '0;
        i_b     = 1'b0;
        #12;
        check("rst_o_ready", {63'd0, o_ready}, 64'd1);
        check("rst_o_valid", {63'd0, o_valid}, 64'd0);
        check("rst_out_num", {32'd0, out_num}, 64'd0);
        check("rst_o_b", {63'd0, o_b}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;

        run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, got, gotb, lat);
        check("lat_op1", 64'(lat), 64'(NC));
        check("op1_out", {32'd0, got}, 64'h0000_FFFF);
        check("op1_b", {63'd0, gotb}, 64'd0);

        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, got, gotb, lat);
`ifdef RSP_S2_PREP_SUB_SAT_EN
        check("op2_out_sat", {32'd0, got}, 64'h0);
`else
        check("op2_out", {32'd0, got}, 64'hFFFF_FFFF);
`endif
        check("op2_b", {63'd0, gotb}, 64'd1);

        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1, got, gotb, lat);
        check("op3_out", {32'd0, got}, 64'h0);
        check("op3_b", {63'd0, gotb}, 64'd0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b0, 1'b1, got, gotb, lat);
        check("op4_out", {32'd0, got}, 64'h1);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, got, gotb, lat);
`ifdef RSP_S2_PREP_SUB_SAT_EN
        check("op5_out_sat", {32'd0, got}, 64'h0);
`else
        check("op5_out", {32'd0, got}, 64'hFFFF_FFFF);
`endif
        check("op5_b", {63'd0, gotb}, 64'd1);

        // Stall in DONE: outputs hold and a new request is ignored.
        run_op(32'hABCD_0000, 32'h0000_1234, 1'b0, 1'b0, got, gotb, lat);
        check("stall_out", {32'd0, got}, 64'hABCC_EDCC);
        hold_num = out_num;
        hold_b   = o_b;
        for (int i = 0; i < 5; i++) begin
            num1    = $urandom;
            num2    = $urandom;
            i_valid = 1'b1;
            @(negedge i_clk);
            check("stall_valid", {63'd0, o_valid}, 64'd1);
            check("stall_ready", {63'd0, o_ready}, 64'd0);
            check("stall_num", {32'd0, out_num}, {32'd0, hold_num});
            check("stall_b", {63'd0, o_b}, {63'd0, hold_b});
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);

        // Reset while the second chunk is being processed.
        while (!o_ready) @(negedge i_clk);
        num1    = 32'h1111_2222;
        num2    = 32'h0000_0001;
        i_b     = 1'b0;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
        check("midrst_o_ready", {63'd0, o_ready}, 64'd1);
        check("midrst_out_num", {32'd0, out_num}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op(32'd5, 32'd3, 1'b0, 1'b1, got, gotb, lat);
        check("post_rst_out", {32'd0, got}, 64'd2);
        check("post_rst_lat", 64'(lat), 64'(NC));

        // Back-to-back random operations with i_valid held high.
        i_ready = 1'b1;
        prev    = -1;
        accepts = 0;
        guard   = 0;
        while (accepts < 100 && guard < 2000) begin
            @(negedge i_clk);
            guard++;
            num1    = $urandom;
            num2    = $urandom;
            i_b     = 1'($urandom);
            i_valid = 1'b1;
            if (o_ready) begin
                if (prev >= 0) check("accept_spacing", 64'(guard - prev), 64'(NC + 2));
                prev = guard;
                accepts++;
            end
        end
        if (accepts < 100) check("b2b_timeout", 64'(accepts), 64'd100);
        @(negedge i_clk);
        i_valid = 1'b0;

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            num1    = ($urandom_range(0, 3) == 0) ? 32'(num2 + $urandom_range(0, 1)) : $urandom;
            num2    = $urandom;
            i_b     = 1'($urandom);
            i_valid = 1'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (10) @(negedge i_clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rsp_s2_prep_sub_seq.md
Name: rsp_s2_prep_sub_seq

Overview:
- Chunk-serial, multi-cycle unsigned subtractor with borrow for the rsp_s2 prep path.
- Computes the difference of two wide operands (DATA_WIDTH*NUM_CHUNKS bits), LSB chunk first, one DATA_WIDTH chunk per clock.
- Borrow ripples chunk to chunk through a registered borrow bit.
- Valid/ready handshake on both input and output; inverse-direction companion of the prep-stage carry adder.

Parameters:
- DATA_WIDTH, 16, chunk width in bits.
- NUM_CHUNKS, 4, number of chunks per operand; must be ≥1. Total width W = DATA_WIDTH*NUM_CHUNKS.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- num1  input  W  minuend.
- num2  input  W  subtrahend.
- i_b  input  1  initial borrow-in.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- out_num  output  W  difference.
- o_b  output  1  final borrow-out (1 = underflow).

Behaviour:
- Interface (decided): one clock, i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, o_ready=1, o_valid=0, out_num=0, o_b=0, chunk index=0, borrow register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, latch num1, num2 and i_b into internal registers, clear the result register and index, then go to RUN.
- RUN: o_ready=0. Each cycle, for chunk k = index:
  - diff = a[k] − b[k] − borrow, computed on DATA_WIDTH+1 bits.
  - Write the low DATA_WIDTH bits into result chunk k.
  - borrow <= diff MSB.
  - index++.
  - When k = NUM_CHUNKS−1, go to DONE.
- Latency: o_valid rises exactly NUM_CHUNKS cycles after the accept edge.
- DONE:
  - o_valid=1; out_num and o_b are driven from registers and stay stable while o_valid && !i_ready.
  - On i_ready, o_valid drops next cycle and the FSM returns to IDLE.
  - Minimum issue interval is NUM_CHUNKS+2 cycles.
- i_valid is ignored outside IDLE; the input bus need not stay stable after the accept edge.
- out_num holds its last value after the handshake until the next accept clears it.
- NUM_CHUNKS=1: RUN lasts one cycle.
- Index width is $clog2(NUM_CHUNKS), minimum 1 bit; no wrap beyond NUM_CHUNKS−1.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.
- Arithmetic: result ≡ num1 − num2 − i_b mod 2^W; o_b=1 iff num1 < num2 + i_b.

Optional Feature:
- Macro: RSP_S2_PREP_SUB_SAT_EN.
- Defined: on entering DONE with final borrow=1, out_num is forced to 0 (saturating floor); o_b is still reported as 1.
- Undefined: out_num is the modulo-2^W wrap result.
- Latency is identical in both builds.

Decomposition:
- Package rsp_s2_prep_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - a localparam function for the index width.
- One natural sub-module: rsp_s2_prep_sub_u.
  - Combinational DATA_WIDTH subtractor: num1, num2, i_b in; out_num, o_b out.
  - Instantiated once per cycle on the selected chunk.

Test Plan (DATA_WIDTH=16, NUM_CHUNKS=2):
- num1=0x0001_0000, num2=0x0000_0001, i_b=0 → o_valid 2 cycles after accept; out_num=0x0000_FFFF, o_b=0.
- num1=0, num2=1, i_b=0 → out_num=0xFFFF_FFFF, o_b=1; with RSP_S2_PREP_SUB_SAT_EN: out_num=0, o_b=1.
- num1=0x1234_5678, num2=0x1234_5677, i_b=1 → out_num=0, o_b=0. Same operands with i_b=0 → out_num=1.
- Hold i_ready=0 for 5 cycles in DONE → o_valid, out_num and o_b stay stable; o_ready=0 throughout; a new i_valid is ignored.
- Pulse i_rst_n low during the RUN cycle of chunk 1 → o_valid=0, o_ready=1 and out_num=0 immediately; a next operation with num1=5, num2=3 gives out_num=2.
- Back-to-back ops with i_ready tied 1 → accepts spaced exactly 4 cycles apart; 100 random vectors match the reference model.
